// File: rtl/l1wb_pkg.sv
// Shared types and width helpers for the L1 merging write buffer.
package l1wb_pkg;

    typedef enum logic {IDLE, PRESENT} drain_state_t;

    // $clog2 that never returns 0, so single-entry parameters still yield a legal vector.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/l1wb_fwd_sel.sv
// Per-byte youngest-match select across buffer entries; also reports the youngest
// matching entry, which the top reuses as the merge-hit search.
module l1wb_fwd_sel
    import l1wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int WORDS  = 4,
    parameter int DEPTH  = 8,
    parameter int TAG_W  = 28,
    parameter int PTR_W  = clog2_min1(DEPTH),
    parameter int WSEL_W = clog2_min1(WORDS)
) (
    input  logic [PTR_W-1:0]                         rd_ptr_i,
    input  logic [TAG_W-1:0]                         tag_i,
    input  logic [WSEL_W-1:0]                        word_i,
    input  logic [DEPTH-1:0]                         vld_i,
    input  logic [DEPTH-1:0][TAG_W-1:0]              tags_i,
    input  logic [DEPTH-1:0][WORDS*DATA_W-1:0]       data_i,
    input  logic [DEPTH-1:0][WORDS*(DATA_W/8)-1:0]   be_i,
    output logic [DATA_W-1:0]                        data_o,
    output logic [DATA_W/8-1:0]                      be_o,
    output logic                                     hit_o,
    output logic [PTR_W-1:0]                         idx_o
);
    localparam int BE_W = DATA_W / 8;

    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so later matches overwrite earlier ones byte by byte.
    always_comb begin
        data_o = '0;
        be_o   = '0;
        hit_o  = 1'b0;
        idx_o  = rd_ptr_i;
        idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_i + PTR_W'(k);
            if (vld_i[idx] && tags_i[idx] == tag_i) begin
                hit_o = 1'b1;
                idx_o = idx;
                for (int b = 0; b < BE_W; b++) begin
                    if (be_i[idx][int'(word_i)*BE_W + b]) begin
                        be_o[b]          = 1'b1;
                        data_o[b*8 +: 8] = data_i[idx][int'(word_i)*DATA_W + b*8 +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/l1_merge_write_buffer.sv
// L1 store write buffer: byte-masked coalescing, load forwarding, drain to L2.
// Store coalescing is enabled by defining L1WB_MERGE_EN; otherwise every store allocates.
module l1_merge_write_buffer
    import l1wb_pkg::*;
#(
    parameter  int DATA_W    = 32,
    parameter  int ADDR_W    = 32,
    parameter  int DEPTH     = 8,
    parameter  int WORDS     = 4,
    parameter  int DRAIN_THR = DEPTH / 2,
    parameter  int AGE_MAX   = 64,
    localparam int BE_W      = DATA_W / 8,
    localparam int OFF_W     = $clog2(WORDS * BE_W),
    localparam int TAG_W     = ADDR_W - OFF_W,
    localparam int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                    clk_l1,
    input  logic                    rst_n,
    input  logic                    st_valid_i,
    output logic                    st_ready_o,
    input  logic [ADDR_W-1:0]       st_addr_i,
    input  logic [DATA_W-1:0]       st_data_i,
    input  logic [BE_W-1:0]         st_be_i,
    input  logic [ADDR_W-1:0]       ld_addr_i,
    output logic [DATA_W-1:0]       ld_fwd_data_o,
    output logic [BE_W-1:0]         ld_fwd_be_o,
    output logic                    ld_fwd_full_o,
    output logic                    dr_valid_o,
    input  logic                    dr_ready_i,
    output logic [TAG_W-1:0]        dr_tag_o,
    output logic [WORDS*DATA_W-1:0] dr_data_o,
    output logic [WORDS*BE_W-1:0]   dr_be_o,
    input  logic                    flush_i,
    output logic                    flush_done_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [CNT_W-1:0]        count_o
);
    localparam int PTR_W  = clog2_min1(DEPTH);
    localparam int WSEL_W = clog2_min1(WORDS);
    localparam int BSEL_W = $clog2(BE_W);
    localparam int AGE_W  = clog2_min1(AGE_MAX + 1);

    logic [DEPTH-1:0]                   vld_q;
    logic [DEPTH-1:0][TAG_W-1:0]        tag_q;
    logic [DEPTH-1:0][WORDS*DATA_W-1:0] data_q;
    logic [DEPTH-1:0][WORDS*BE_W-1:0]   be_q;
    logic [PTR_W-1:0]  w_ptr_q, r_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [AGE_W-1:0]  age_q;
    logic              flush_pend_q;
    drain_state_t      state_q, state_d;
    logic [DATA_W-1:0] ld_fwd_data_q, fwd_data;
    logic [BE_W-1:0]   ld_fwd_be_q, fwd_be;
    logic              fwd_hit_unused;
    logic [PTR_W-1:0]  fwd_idx_unused;

    logic [TAG_W-1:0]  st_tag, ld_tag;
    logic [WSEL_W-1:0] st_word, ld_word;
    logic              merge_hit, st_acc, alloc, pop, drain_go;
    logic [PTR_W-1:0]  merge_idx, tgt;

    assign st_tag  = st_addr_i[ADDR_W-1:OFF_W];
    assign ld_tag  = ld_addr_i[ADDR_W-1:OFF_W];
    assign st_word = WSEL_W'(st_addr_i[OFF_W-1:0] >> BSEL_W);
    assign ld_word = WSEL_W'(ld_addr_i[OFF_W-1:0] >> BSEL_W);

`ifdef L1WB_MERGE_EN
    logic [DEPTH-1:0]  lock_mask;
    logic [DATA_W-1:0] m_data_unused;
    logic [BE_W-1:0]   m_be_unused;

    // The presented head is frozen; a store to its tag must open a fresh entry.
    assign lock_mask = (state_q == PRESENT) ? (DEPTH'(1) << r_ptr_q) : '0;

    l1wb_fwd_sel #(.DATA_W(DATA_W), .WORDS(WORDS), .DEPTH(DEPTH), .TAG_W(TAG_W)) u_merge (
        .rd_ptr_i (r_ptr_q),
        .tag_i    (st_tag),
        .word_i   (st_word),
        .vld_i    (vld_q & ~lock_mask),
        .tags_i   (tag_q),
        .data_i   (data_q),
        .be_i     (be_q),
        .data_o   (m_data_unused),
        .be_o     (m_be_unused),
        .hit_o    (merge_hit),
        .idx_o    (merge_idx)
    );
`else
    assign merge_hit = 1'b0;
    assign merge_idx = w_ptr_q;
`endif

    l1wb_fwd_sel #(.DATA_W(DATA_W), .WORDS(WORDS), .DEPTH(DEPTH), .TAG_W(TAG_W)) u_fwd (
        .rd_ptr_i (r_ptr_q),
        .tag_i    (ld_tag),
        .word_i   (ld_word),
        .vld_i    (vld_q),
        .tags_i   (tag_q),
        .data_i   (data_q),
        .be_i     (be_q),
        .data_o   (fwd_data),
        .be_o     (fwd_be),
        .hit_o    (fwd_hit_unused),
        .idx_o    (fwd_idx_unused)
    );

    assign full_o       = (count_q == CNT_W'(DEPTH));
    assign empty_o      = (count_q == '0);
    assign count_o      = count_q;
    assign st_ready_o   = !flush_pend_q && (!full_o || merge_hit);
    assign st_acc       = st_valid_i && st_ready_o;
    assign alloc        = st_acc && !merge_hit;
    assign pop          = (state_q == PRESENT) && dr_ready_i;
    assign tgt          = merge_hit ? merge_idx : w_ptr_q;
    assign flush_done_o = flush_pend_q && empty_o;
    assign drain_go     = !empty_o && (count_q >= CNT_W'(DRAIN_THR) || flush_pend_q ||
                          (AGE_MAX != 0 && age_q == AGE_W'(AGE_MAX)));

    assign ld_fwd_data_o = ld_fwd_data_q;
    assign ld_fwd_be_o   = ld_fwd_be_q;

    always_ff @(posedge clk_l1 or negedge rst_n) begin
        if (!rst_n) begin
            vld_q         <= '0;
            be_q          <= '0;
            w_ptr_q       <= '0;
            r_ptr_q       <= '0;
            count_q       <= '0;
            age_q         <= '0;
            flush_pend_q  <= 1'b0;
            ld_fwd_data_q <= '0;
            ld_fwd_be_q   <= '0;
            ld_fwd_full_o <= 1'b0;
        end else begin
            if (pop) vld_q[r_ptr_q] <= 1'b0;
            if (alloc) begin
                vld_q[w_ptr_q] <= 1'b1;
                be_q[w_ptr_q]  <= '0;
            end
            if (st_acc)
                be_q[tgt][int'(st_word)*BE_W +: BE_W] <= alloc ? st_be_i
                    : (be_q[tgt][int'(st_word)*BE_W +: BE_W] | st_be_i);
            w_ptr_q <= w_ptr_q + PTR_W'(alloc);
            r_ptr_q <= r_ptr_q + PTR_W'(pop);
            case ({alloc, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (pop)
                age_q <= '0;
            else if (state_q == IDLE && !empty_o && age_q != AGE_W'(AGE_MAX))
                age_q <= age_q + 1'b1;
            if (flush_i)
                flush_pend_q <= 1'b1;
            else if (flush_pend_q && empty_o)
                flush_pend_q <= 1'b0;
            ld_fwd_data_q <= fwd_data;
            ld_fwd_be_q   <= fwd_be;
            ld_fwd_full_o <= &fwd_be;
        end
    end

    // Payload array is deliberately left unreset; valid bits and masks gate all reads.
    always_ff @(posedge clk_l1) begin
        if (st_acc) begin
            if (alloc) tag_q[w_ptr_q] <= st_tag;
            for (int b = 0; b < BE_W; b++)
                if (st_be_i[b])
                    data_q[tgt][int'(st_word)*DATA_W + b*8 +: 8] <= st_data_i[b*8 +: 8];
        end
    end

    always_ff @(posedge clk_l1 or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (drain_go)   state_d = PRESENT;
            PRESENT: if (dr_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dr_valid_o = 1'b0;
        dr_tag_o   = '0;
        dr_data_o  = '0;
        dr_be_o    = '0;
        if (state_q == PRESENT) begin
            dr_valid_o = 1'b1;
            dr_tag_o   = tag_q[r_ptr_q];
            dr_data_o  = data_q[r_ptr_q];
            dr_be_o    = be_q[r_ptr_q];
        end
    end

endmodule

// File: tb/tb_l1_merge_write_buffer.sv
// Directed bench for l1_merge_write_buffer: vector table plus multi-cycle sequences.
module tb_l1_merge_write_buffer;

`ifdef L1WB_MERGE_EN
    localparam bit MERGE = 1'b1;
`else
    localparam bit MERGE = 1'b0;
`endif
    localparam logic [2:0] MC = MERGE ? 3'd1 : 3'd2;

    logic         clk_l1 = 1'b0;
    logic         rst_n  = 1'b0;
    logic         st_valid, st_ready, ld_fwd_full, dr_valid, dr_ready, flush, flush_done;
    logic         full, empty;
    logic [31:0]  st_addr, st_data, ld_addr, ld_fwd_data;
    logic [3:0]   st_be, ld_fwd_be;
    logic [27:0]  dr_tag;
    logic [127:0] dr_data;
    logic [15:0]  dr_be;
    logic [2:0]   count;

    int n_chk  = 0;
    int n_fail = 0;

    l1_merge_write_buffer #(
        .DATA_W(32), .ADDR_W(32), .DEPTH(4), .WORDS(4), .DRAIN_THR(3), .AGE_MAX(8)
    ) dut (
        .clk_l1        (clk_l1),
        .rst_n         (rst_n),
        .st_valid_i    (st_valid),
        .st_ready_o    (st_ready),
        .st_addr_i     (st_addr),
        .st_data_i     (st_data),
        .st_be_i       (st_be),
        .ld_addr_i     (ld_addr),
        .ld_fwd_data_o (ld_fwd_data),
        .ld_fwd_be_o   (ld_fwd_be),
        .ld_fwd_full_o (ld_fwd_full),
        .dr_valid_o    (dr_valid),
        .dr_ready_i    (dr_ready),
        .dr_tag_o      (dr_tag),
        .dr_data_o     (dr_data),
        .dr_be_o       (dr_be),
        .flush_i       (flush),
        .flush_done_o  (flush_done),
        .full_o        (full),
        .empty_o       (empty),
        .count_o       (count)
    );

    always #5 clk_l1 = ~clk_l1;

    typedef struct {
        bit          rst;
        bit          st_v;
        logic [31:0] st_a;
        logic [31:0] st_d;
        logic [3:0]  st_be;
        logic [31:0] ld_a;
        logic [2:0]  exp_cnt;
        bit          exp_full;
        logic [31:0] exp_fd;
        logic [3:0]  exp_fbe;
        bit          exp_ff;
        bit          exp_dv;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_l1);
        #1;
    endtask

    task automatic idle_inputs();
        st_valid = 1'b0; st_addr = '0; st_data = '0; st_be = '0;
        dr_ready = 1'b0; flush = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        ld_addr = '0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        st_valid = 1'b1; st_addr = a; st_data = d; st_be = be;
        tick();
        st_valid = 1'b0;
    endtask

    initial begin
        int n, done_cnt, dv_cnt;

        // rst, st_v, st_a, st_d, st_be, ld_a, cnt, full, fwd_data, fwd_be, fwd_full, dr_valid
        tbl[0] = '{1'b1, 1'b1, 32'h100, 32'h0000AAAA, 4'h3, 32'h100, 3'd1, 1'b0, 32'h0,        4'h0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 32'h100, 32'hBBBB0000, 4'hC, 32'h100, MC,   1'b0, 32'h0000AAAA, 4'h3, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 32'h100, MC,   1'b0, 32'hBBBBAAAA, 4'hF, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 32'h104, MC,   1'b0, 32'h0,        4'h0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 32'h200, MC,   1'b0, 32'h0,        4'h0, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 32'h000, 32'h11111111, 4'hF, 32'h010, 3'd1, 1'b0, 32'h0,        4'h0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 32'h010, 32'h22222222, 4'hF, 32'h010, 3'd2, 1'b0, 32'h0,        4'h0, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 32'h020, 32'h33333333, 4'hF, 32'h010, 3'd3, 1'b0, 32'h22222222, 4'hF, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 1'b1, 32'h030, 32'h44444444, 4'hF, 32'h010, 3'd4, 1'b1, 32'h22222222, 4'hF, 1'b1, 1'b1};
        tbl[9] = '{1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 32'h020, 3'd4, 1'b1, 32'h33333333, 4'hF, 1'b1, 1'b1};

        do_reset();
        chk("reset_state",
            {st_ready, dr_valid, flush_done, full, empty, count, ld_fwd_data, ld_fwd_be, ld_fwd_full},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 32'h0, 4'h0, 1'b0});

        for (int i = 0; i < 10; i++) begin
            if (tbl[i].rst) do_reset();
            st_valid = tbl[i].st_v; st_addr = tbl[i].st_a; st_data = tbl[i].st_d;
            st_be = tbl[i].st_be; ld_addr = tbl[i].ld_a; dr_ready = 1'b0;
            tick();
            chk($sformatf("vec%0d", i),
                {count, full, ld_fwd_data, ld_fwd_be, ld_fwd_full, dr_valid},
                {tbl[i].exp_cnt, tbl[i].exp_full, tbl[i].exp_fd, tbl[i].exp_fbe,
                 tbl[i].exp_ff, tbl[i].exp_dv});
        end

        // Full buffer with head presented: readiness per tag class.
        st_valid = 1'b1; st_addr = 32'h040; #1;
        chk("ready_full_new_tag", st_ready, 1'b0);
        st_addr = 32'h000; #1;
        chk("ready_full_locked_head", st_ready, 1'b0);
        st_addr = 32'h010; #1;
        chk("ready_full_mergeable", st_ready, MERGE);
        st_valid = 1'b0;

        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("drain_hold%0d", i), {dr_valid, dr_tag, dr_data[31:0], dr_be},
                {1'b1, 28'h0, 32'h11111111, 16'h000F});
        end

        // Pop while full: the concurrent store must not allocate.
        dr_ready = 1'b1; st_valid = 1'b1; st_addr = 32'h040; st_data = 32'h55555555; st_be = 4'hF;
        tick();
        chk("pop_when_full", {count, dr_valid}, {3'd3, 1'b0});
        dr_ready = 1'b0; st_valid = 1'b0;
        tick();
        chk("next_head", {dr_valid, dr_tag}, {1'b1, 28'h1});
        dr_ready = 1'b1; st_valid = 1'b1; st_addr = 32'h050; st_data = 32'h66666666; st_be = 4'hF; #1;
        chk("ready_not_full", st_ready, 1'b1);
        tick();
        chk("pop_and_accept", {count, dr_valid}, {3'd3, 1'b0});
        idle_inputs(); ld_addr = 32'h050;
        tick();
        chk("fwd_after_pop_accept", {ld_fwd_data, ld_fwd_be, ld_fwd_full}, {32'h66666666, 4'hF, 1'b1});

        // Aging: one lone entry drains after AGE_MAX+1 cycles.
        do_reset();
        store(32'h300, 32'hDDDDDDDD, 4'hF);
        n = 0;
        while (!dr_valid && n < 20) begin
            tick();
            n++;
        end
        chk("age_drain_latency", n, 9);

        // Store to the locked head's tag opens a new entry; youngest bytes win on loads.
        store(32'h300, 32'h000000CC, 4'h1);
        chk("locked_head_alloc", count, 3'd2);
        ld_addr = 32'h300;
        store(32'h300, 32'h0000EE00, 4'h2);
        chk("young_entry_merge", count, MERGE ? 3'd2 : 3'd3);
        chk("fwd_over_head", {ld_fwd_data, ld_fwd_be}, {32'hDDDDDDCC, 4'hF});
        tick();
        chk("fwd_youngest", {ld_fwd_data, ld_fwd_be, ld_fwd_full}, {32'hDDDDEECC, 4'hF, 1'b1});
        chk("head_untouched", {dr_valid, dr_tag, dr_data[31:0]}, {1'b1, 28'h30, 32'hDDDDDDDD});

        // Flush with two entries and a ready sink.
        do_reset();
        store(32'h000, 32'h11111111, 4'hF);
        store(32'h010, 32'h22222222, 4'hF);
        dr_ready = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_blocks_store", {st_ready, flush_done}, {1'b0, 1'b0});
        done_cnt = 0; dv_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            done_cnt += int'(flush_done);
            dv_cnt   += int'(dr_valid);
        end
        chk("flush_done_pulses", done_cnt, 1);
        chk("flush_drained", dv_cnt, 2);
        chk("flush_end_state", {empty, count, st_ready}, {1'b1, 3'd0, 1'b1});
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_empty_done", flush_done, 1'b1);
        tick();
        chk("flush_empty_done_drop", flush_done, 1'b0);

        // Asynchronous reset in the middle of a pending drain.
        dr_ready = 1'b0; ld_addr = 32'h000;
        store(32'h000, 32'h11111111, 4'hF);
        store(32'h010, 32'h22222222, 4'hF);
        store(32'h020, 32'h33333333, 4'hF);
        tick();
        chk("pre_reset_busy", {dr_valid, ld_fwd_full}, {1'b1, 1'b1});
        #2 rst_n = 1'b0;
        #1;
        chk("midrun_reset",
            {st_ready, dr_valid, dr_tag, dr_be, ld_fwd_data, ld_fwd_be, ld_fwd_full,
             flush_done, full, empty, count},
            {1'b1, 1'b0, 28'h0, 16'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0});
        chk("midrun_reset_data", dr_data, 128'h0);
        @(posedge clk_l1);
        #1 rst_n = 1'b1;
        tick();
        chk("post_reset_idle", {dr_valid, count, empty}, {1'b0, 3'd0, 1'b1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
